adaptive_trimmed_filter: RTL and testbench



---
 rtl/adaptive_trimmed_pkg.sv | 28 ++
 rtl/adaptive_trimmed_filter_line_buffer.sv | 43 ++++
 rtl/adaptive_trimmed_filter.sv | 187 ++++++++++++++++++
 tb/tb_adaptive_trimmed_filter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/adaptive_trimmed_pkg.sv
// Shared types and arithmetic helpers for the adaptive trimmed-mean filter.
package adaptive_trimmed_pkg;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  localparam int NBR_CNT = 8;

  function automatic logic is_noisy(input int unsigned x, input int unsigned lo,
                                    input int unsigned hi);
    return (x <= lo) || (x >= hi);
  endfunction

  // Rounded mean with one constant divisor per neighbour count.
  function automatic int unsigned round_div(input int unsigned sum, input logic [3:0] cnt);
    case (cnt)
      4'd1:    return sum;
      4'd2:    return (sum + 1) / 2;
      4'd3:    return (sum + 1) / 3;
      4'd4:    return (sum + 2) / 4;
      4'd5:    return (sum + 2) / 5;
      4'd6:    return (sum + 3) / 6;
      4'd7:    return (sum + 3) / 7;
      4'd8:    return (sum + 4) / 8;
      default: return sum;
    endcase
  endfunction

endpackage

// File: rtl/adaptive_trimmed_filter_line_buffer.sv
// One-line delay: dout is the pixel written IMG_W advances ago. The write-back
// port overwrites the most recently written entry with a corrected value.
module line_buffer
  import adaptive_trimmed_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              adv,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  input  logic              wb_en,
  input  logic [DATA_W-1:0] wb_data
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     last_ptr;

  assign dout = mem[wr_ptr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr   <= '0;
      last_ptr <= '0;
    end else if (adv) begin
      wr_ptr   <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      last_ptr <= wr_ptr;
    end
  end

  // last_ptr never equals wr_ptr, so both writes can land in the same cycle.
  always_ff @(posedge clk) begin
    if (adv)   mem[wr_ptr]   <= din;
    if (wb_en) mem[last_ptr] <= wb_data;
  end

endmodule

// File: rtl/adaptive_trimmed_filter.sv
// Streaming 3x3 adaptive trimmed-mean filter: noisy interior pixels are
// replaced by the rounded mean of their clean neighbours.
//
// state | meaning
// IDLE  | waiting for an accepted pix_sof
// RUN   | accepting raster pixels of the current frame
// FLUSH | IMG_W+1 data-less advances to drain the last centres
module adaptive_trimmed_filter
  import adaptive_trimmed_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int IMG_W    = 256,
  parameter int IMG_H    = 256,
  parameter int NOISE_LO = 0,
  parameter int NOISE_HI = 2**DATA_W - 1,
  parameter int FEEDBACK = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] pix_in,
  input  logic              pix_valid,
  input  logic              pix_sof,
  output logic              pix_ready,
  output logic [DATA_W-1:0] pix_out,
  output logic              out_valid,
  output logic              out_sof,
  output logic              out_eof,
  output logic              busy
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int FW = $clog2(IMG_W + 1);
  localparam int LW = $clog2(IMG_W + 2);
  localparam int SW = DATA_W + 3;
  localparam int unsigned NLO = 32'(NOISE_LO);
  localparam int unsigned NHI = 32'(NOISE_HI);
  localparam logic [CW-1:0] COL_LAST   = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(IMG_H - 1);
  localparam logic [FW-1:0] FLUSH_LOAD = FW'(IMG_W);
  localparam logic [LW-1:0] LEAD_LOAD  = LW'(IMG_W);

  state_t            state;
  logic [RW-1:0]     in_row, out_row;
  logic [CW-1:0]     in_col, out_col;
  logic [FW-1:0]     flush_cnt;
  logic [LW-1:0]     lead_cnt;
  logic              ready_q, busy_q;
  logic              accept, sof_adv, adv, emit, border, lb1_wb;
  logic [DATA_W-1:0] x, lb0_out, lb1_out, centre, result;
  logic [DATA_W-1:0] t [2];
  logic [DATA_W-1:0] m [2];
  logic [DATA_W-1:0] b [2];
  logic [DATA_W-1:0] nb [NBR_CNT];
  logic [SW-1:0]     clean_sum, all_sum;
  logic [3:0]        clean_cnt;

  assign pix_ready = ready_q;
  assign busy      = busy_q;
  assign accept    = pix_valid & ready_q;
  assign sof_adv   = accept & pix_sof;
  assign adv       = (state == FLUSH) | (accept & (pix_sof | (state == RUN)));
  // Centres start appearing once IMG_W+1 pixels sit ahead of them.
  assign emit      = adv & ~sof_adv & (lead_cnt == '0);
  assign x         = (state == FLUSH) ? '0 : pix_in;
  assign centre    = m[1];
  assign border    = (out_row == '0) | (out_row == ROW_LAST) |
                     (out_col == '0) | (out_col == COL_LAST);
  assign lb1_wb    = emit & (FEEDBACK != 0);

  line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_lb0 (
    .clk(clk), .rst(rst), .adv(adv), .din(x), .dout(lb0_out),
    .wb_en(1'b0), .wb_data('0)
  );

  line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_lb1 (
    .clk(clk), .rst(rst), .adv(adv), .din(lb0_out), .dout(lb1_out),
    .wb_en(lb1_wb), .wb_data(result)
  );

  // Window as seen after this advance: registered columns plus the new right column.
  always_comb begin
    nb[0] = t[0];  nb[1] = t[1];  nb[2] = lb1_out;
    nb[3] = m[0];                 nb[4] = lb0_out;
    nb[5] = b[0];  nb[6] = b[1];  nb[7] = x;
    clean_sum = '0;
    all_sum   = '0;
    clean_cnt = '0;
    for (int i = 0; i < NBR_CNT; i++) begin
      all_sum = all_sum + SW'(nb[i]);
      if (!is_noisy(32'(nb[i]), NLO, NHI)) begin
        clean_sum = clean_sum + SW'(nb[i]);
        clean_cnt = clean_cnt + 4'd1;
      end
    end
    if (border || !is_noisy(32'(centre), NLO, NHI))
      result = centre;
    else if (clean_cnt == 4'd0)
      result = DATA_W'(round_div(32'(all_sum), 4'd8));
    else
      result = DATA_W'(round_div(32'(clean_sum), clean_cnt));
  end

  // With feedback the corrected centre becomes the next window's left neighbour.
  always_ff @(posedge clk) begin
    if (adv) begin
      t[0] <= t[1];
      t[1] <= lb1_out;
      m[0] <= lb1_wb ? result : m[1];
      m[1] <= lb0_out;
      b[0] <= b[1];
      b[1] <= x;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      in_row    <= '0;
      in_col    <= '0;
      out_row   <= '0;
      out_col   <= '0;
      flush_cnt <= '0;
      lead_cnt  <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      pix_out   <= '0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
    end else begin
      out_valid <= emit;
      out_sof   <= emit & (out_row == '0) & (out_col == '0);
      out_eof   <= emit & (out_row == ROW_LAST) & (out_col == COL_LAST);
      if (emit) begin
        pix_out <= result;
        if (out_col == COL_LAST) begin
          out_col <= '0;
          out_row <= out_row + 1'b1;
        end else begin
          out_col <= out_col + 1'b1;
        end
      end
      if (adv && lead_cnt != '0) lead_cnt <= lead_cnt - 1'b1;

      if (sof_adv) begin
        state    <= RUN;
        in_row   <= '0;
        in_col   <= CW'(1);
        out_row  <= '0;
        out_col  <= '0;
        lead_cnt <= LEAD_LOAD;
        ready_q  <= 1'b1;
        busy_q   <= 1'b1;
      end else begin
        case (state)
          IDLE: ready_q <= 1'b1;
          RUN: begin
            if (accept) begin
              if (in_row == ROW_LAST && in_col == COL_LAST) begin
                state     <= FLUSH;
                flush_cnt <= FLUSH_LOAD;
                ready_q   <= 1'b0;
              end else if (in_col == COL_LAST) begin
                in_col <= '0;
                in_row <= in_row + 1'b1;
              end else begin
                in_col <= in_col + 1'b1;
              end
            end
          end
          FLUSH: begin
            if (flush_cnt == '0) begin
              state   <= IDLE;
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              flush_cnt <= flush_cnt - 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adaptive_trimmed_filter.sv
// Directed bench for adaptive_trimmed_filter on 4x4 frames, with one instance
// per feedback setting driven from the same pixel stream.
module tb_adaptive_trimmed_filter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] pix_in;
  logic       pix_valid, pix_sof;
  logic [7:0] pix_out0, pix_out1;
  logic       pix_ready0, out_valid0, out_sof0, out_eof0, busy0;
  logic       pix_ready1, out_valid1, out_sof1, out_eof1, busy1;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] q0p[$], q1p[$];
  bit         q0s[$], q0e[$];

  logic [7:0] flat_f [16], salt_f [16], pep_f [16], pep_e [16];
  logic [7:0] nz_f [16], nz_e0 [16], nz_e1 [16];

  adaptive_trimmed_filter #(.DATA_W(8), .IMG_W(4), .IMG_H(4), .NOISE_LO(0),
                            .NOISE_HI(255), .FEEDBACK(0)) dut0 (
    .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid), .pix_sof(pix_sof),
    .pix_ready(pix_ready0), .pix_out(pix_out0), .out_valid(out_valid0),
    .out_sof(out_sof0), .out_eof(out_eof0), .busy(busy0)
  );

  adaptive_trimmed_filter #(.DATA_W(8), .IMG_W(4), .IMG_H(4), .NOISE_LO(0),
                            .NOISE_HI(255), .FEEDBACK(1)) dut1 (
    .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid), .pix_sof(pix_sof),
    .pix_ready(pix_ready1), .pix_out(pix_out1), .out_valid(out_valid1),
    .out_sof(out_sof1), .out_eof(out_eof1), .busy(busy1)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (out_valid0) begin
      q0p.push_back(pix_out0);
      q0s.push_back(out_sof0);
      q0e.push_back(out_eof0);
    end
    if (out_valid1) q1p.push_back(pix_out1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [7:0] p, input logic s);
    pix_valid = 1'b1;
    pix_in    = p;
    pix_sof   = s;
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
  endtask

  task automatic send(input logic [7:0] f [16], input int first, input int n);
    for (int i = first; i < first + n; i++) drive(f[i], i == 0);
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!pix_ready0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("ready_wait", 32'(pix_ready0), 32'd1);
  endtask

  task automatic wait_outs(input int n);
    int k = 0;
    while ((q0p.size() < n || q1p.size() < n) && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("out_count0", q0p.size(), n);
    chk("out_count1", q1p.size(), n);
  endtask

  task automatic clear_q();
    q0p.delete();
    q0s.delete();
    q0e.delete();
    q1p.delete();
  endtask

  task automatic check_frame(input string tag, input int base,
                             input logic [7:0] e0 [16], input logic [7:0] e1 [16]);
    for (int i = 0; i < 16; i++) begin
      int idx = base + i;
      chk($sformatf("%s_fb0[%0d]", tag, i),
          (idx < q0p.size()) ? 32'(q0p[idx]) : 32'hFFFF_FFFF, 32'(e0[i]));
      chk($sformatf("%s_fb1[%0d]", tag, i),
          (idx < q1p.size()) ? 32'(q1p[idx]) : 32'hFFFF_FFFF, 32'(e1[i]));
      chk($sformatf("%s_sof[%0d]", tag, i),
          (idx < q0s.size()) ? 32'(q0s[idx]) : 32'hFFFF_FFFF, 32'(i == 0));
      chk($sformatf("%s_eof[%0d]", tag, i),
          (idx < q0e.size()) ? 32'(q0e[idx]) : 32'hFFFF_FFFF, 32'(i == 15));
    end
  endtask

  initial begin
    int flush_cycles;

    flat_f = '{default: 8'd100};
    salt_f = flat_f;  salt_f[5] = 8'd255;
    pep_f  = flat_f;  pep_f[0] = 8'd255;  pep_f[5] = 8'd0;  pep_f[10] = 8'd40;
    pep_e  = pep_f;   pep_e[5] = 8'd91;
    nz_f   = '{8'd255, 8'd255, 8'd255, 8'd255,
               8'd60,  8'd0,   8'd0,   8'd255,
               8'd0,   8'd0,   8'd0,   8'd0,
               8'd100, 8'd100, 8'd100, 8'd100};
    nz_e0 = nz_f;  nz_e0[5] = 8'd60;  nz_e0[6] = 8'd128;  nz_e0[9] = 8'd90;  nz_e0[10] = 8'd100;
    nz_e1 = nz_f;  nz_e1[5] = 8'd60;  nz_e1[6] = 8'd60;   nz_e1[9] = 8'd80;  nz_e1[10] = 8'd83;

    rst = 1'b0;  pix_valid = 1'b0;  pix_sof = 1'b0;  pix_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pix_out", 32'(pix_out0), 0);
    chk("rst_out_valid", 32'(out_valid0), 0);
    chk("rst_out_sof", 32'(out_sof0), 0);
    chk("rst_out_eof", 32'(out_eof0), 0);
    chk("rst_busy", 32'(busy0), 0);
    chk("rst_ready", 32'(pix_ready0), 0);
    rst = 1'b1;
    wait_ready();

    // Reset in the middle of a frame that has already produced output.
    send(flat_f, 0, 8);
    chk("pre_rst_busy", 32'(busy0), 1);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("midrst_valid[%0d]", c), 32'(out_valid0), 0);
      chk($sformatf("midrst_pix[%0d]", c), 32'(pix_out0), 0);
      chk($sformatf("midrst_busy[%0d]", c), 32'(busy0), 0);
      chk($sformatf("midrst_ready[%0d]", c), 32'(pix_ready0), 0);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_ready", 32'(pix_ready0), 1);
    chk("post_rst_busy", 32'(busy0), 0);
    clear_q();
    for (int i = 0; i < 6; i++) drive(8'd100, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    chk("no_out_without_sof", q0p.size(), 0);
    chk("idle_without_sof", 32'(busy0), 0);

    // Flat frame, flush length, then a salt frame started on the drain cycle.
    clear_q();
    send(flat_f, 0, 16);
    flush_cycles = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (pix_ready0) break;
      flush_cycles++;
    end
    chk("flush_cycles", flush_cycles, 5);
    chk("drain_eof_valid", 32'(out_valid0 & out_eof0), 1);
    send(salt_f, 0, 16);
    wait_outs(32);
    check_frame("flat", 0, flat_f, flat_f);
    check_frame("salt", 16, flat_f, flat_f);

    clear_q();
    wait_ready();
    send(pep_f, 0, 16);
    wait_ready();
    send(nz_f, 0, 16);
    wait_outs(32);
    check_frame("pepper", 0, pep_e, pep_e);
    check_frame("allnoisy", 16, nz_e0, nz_e1);

    // Abort: a new pix_sof arrives where pixel (2,1) of the old frame would be.
    clear_q();
    wait_ready();
    send(flat_f, 0, 9);
    send(pep_f, 0, 1);
    chk("abort_prior_outs", q0p.size(), 4);
    chk("abort_valid_low", 32'(out_valid0), 0);
    chk("abort_busy", 32'(busy0), 1);
    clear_q();
    send(pep_f, 1, 15);
    wait_outs(16);
    check_frame("abort", 0, pep_e, pep_e);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
